mul_unit_r4: RTL and testbench
==============================

MUL_UNIT_R4 -- requirements
Module: mul_unit_r4

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/result width; it must be even and at least 8.
REQ-002 SHALL have parameter TAG_W, default 4, meaning reservation-station tag width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: issue request, honoured only while ready=1.
REQ-006 SHALL have port ready, output, 1 bit: unit idle and able to accept an issue.
REQ-007 SHALL have port op, input, 2 bits: operation select; 0=MUL, 1=MULH, 2=MULHSU, 3=MULHU.
REQ-008 SHALL have ports src_a and src_b, input, WIDTH bits each: the multiplicand (rs1) and the multiplier (rs2).
REQ-009 SHALL have port tag_in, input, TAG_W bits: destination tag, captured at issue.
REQ-010 SHALL have port flush, input, 1 bit: squash of the in-flight operation.
REQ-011 SHALL have ports cdb_valid (input, 1 bit) and cdb_tag (input, TAG_W bits): CDB broadcast seen by this unit.
REQ-012 SHALL have port result_valid, output, 1 bit: result waiting for CDB grant.
REQ-013 SHALL have port tag_out, output, TAG_W bits: tag of the held result.
REQ-014 SHALL have port result, output, WIDTH bits: the low or high product half, selected by the captured op.

Function
REQ-015 SHALL implement the FSM IDLE -> CALC -> DONE -> IDLE; ready=1 only in IDLE.
REQ-016 SHALL, on start&&ready, capture the operands, op and tag_in and enter CALC; start is ignored in CALC and DONE.
REQ-017 SHALL extend each operand to WIDTH+2 bits: sign-extended if it is signed for the op (src_a: MUL/MULH/MULHSU; src_b: MUL/MULH), zero-extended otherwise.
REQ-018 SHALL use radix-4 Booth recoding of the extended src_b, retiring one digit (2 bits) per CALC cycle; ITER = WIDTH/2+1 cycles in total.
REQ-019 SHALL keep a down-counter loaded with ITER at issue; when it reaches zero, the next edge enters DONE with result_valid=1. For WIDTH=32, result_valid rises 18 edges after the accepting edge.
REQ-020 SHALL drive result with product bits [WIDTH-1:0] for MUL, and bits [2*WIDTH-1:WIDTH] otherwise.
REQ-021 SHALL hold result, tag_out and result_valid stable in DONE until cdb_valid && cdb_tag==tag_out; the next edge then enters IDLE with result_valid=0.
REQ-022 SHALL not clear result_valid for a CDB broadcast carrying a different tag.
REQ-023 SHALL not accept an issue in the retiring cycle; ready rises the edge after retire.
REQ-024 SHALL, when flush=1 in any state, enter IDLE on the next edge with result_valid=0; flush takes priority over start and over CDB retire.

Reset
REQ-025 SHALL, on reset_n=0 (asynchronous, mid-operation included), force state=IDLE, ready=1, result_valid=0, result=0, tag_out=0 and counter=0.
REQ-026 SHALL leave operand datapath registers with no reset requirement.

Configuration
REQ-027 SHALL use the macro MUL_EARLY_ZERO_EN: when defined, an issue with src_a==0 or src_b==0 bypasses CALC and enters DONE on the next edge with result=0.
REQ-028 SHALL, without MUL_EARLY_ZERO_EN, give every op the full ITER latency.

Structure
REQ-029 SHALL place the mul_op_t enum (MUL, MULH, MULHSU, MULHU), the state_t enum and an ITER-computing function in the shared package mul_pkg.
REQ-030 SHALL implement Booth digit recoding (3 bits -> partial product of 0, ±M or ±2M, WIDTH+2 bits) in the combinational sub-module booth_r4_recode.

Verification
REQ-031 SHALL cover: MUL with 7 and 0xFFFFFFFD -> result 0xFFFFFFEB after 18 cycles.
REQ-032 SHALL cover: MULH with 0x80000000 and 0x80000000 -> 0x40000000; MULHU with 0xFFFFFFFF and 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU with 0xFFFFFFFF and 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-033 SHALL cover CDB hold: result pending under tag 5, cdb_tag=3 -> result_valid stays 1; then cdb_tag=5 -> result_valid=0 and ready=1 one cycle later.
REQ-034 SHALL cover flush during CALC (cycle 6) -> IDLE next edge, no result_valid; a new issue then completes correctly.
REQ-035 SHALL cover reset_n low mid-CALC -> all outputs at reset values immediately; start held during DONE -> ignored.
REQ-036 SHALL, with MUL_EARLY_ZERO_EN, cover MUL 0 x 0x1234 -> result_valid one edge after issue, result=0.

Source files
------------

// File: rtl/mul_pkg.sv
// mul_pkg -- shared types and helpers for the radix-4 Booth multiply unit.
//   mul_op_t   : operation encoding carried on the op port (MUL/MULH/MULHSU/MULHU)
//   state_t    : control FSM states (IDLE -> CALC -> DONE -> IDLE)
//   calc_iter  : number of Booth digits (CALC cycles) for a given operand width
package mul_pkg;

  typedef enum logic [1:0] {
    MUL    = 2'd0,
    MULH   = 2'd1,
    MULHSU = 2'd2,
    MULHU  = 2'd3
  } mul_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Operands are widened by two bits so that unsigned values become positive
  // two's-complement numbers; that width holds width/2+1 radix-4 digits.
  function automatic int calc_iter(input int width);
    return width / 2 + 1;
  endfunction

endpackage

// File: rtl/booth_r4_recode.sv
// booth_r4_recode -- combinational radix-4 Booth digit recoder.
//   digit : {b[2i+1], b[2i], b[2i-1]} window of the multiplier
//   mcand : sign-correct multiplicand M, EW bits
//   pp    : partial product 0, +M, +2M, -M or -2M, EW bits
// EW must leave headroom for 2M (the caller passes operand width + 2).
module booth_r4_recode
  import mul_pkg::*;
#(
  parameter int EW = 34
) (
  input  logic [2:0]    digit,
  input  logic [EW-1:0] mcand,
  output logic [EW-1:0] pp
);

  always_comb begin
    pp = '0;
    unique case (digit)
      3'b001, 3'b010: pp = mcand;
      3'b011:         pp = mcand << 1;
      3'b100:         pp = -(mcand << 1);
      3'b101, 3'b110: pp = -mcand;
      default:        pp = '0;
    endcase
  end

endmodule

// File: rtl/mul_unit_r4.sv
// mul_unit_r4 -- iterative radix-4 Booth multiplier for a reservation-station
// style pipeline. One Booth digit is retired per CALC cycle; the finished
// result is held until the CDB broadcasts its tag.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   start / ready         issue handshake (issue accepted only in IDLE)
//   op, src_a, src_b      operation and operands (rs1, rs2)
//   tag_in                destination tag captured at issue
//   flush                 squash of the in-flight operation (highest priority)
//   cdb_valid, cdb_tag    CDB broadcast; matching tag retires the held result
//   result_valid, tag_out, result   held result
//
// Optional build macro:
//   MUL_EARLY_ZERO_EN     an issue with a zero operand skips CALC and
//                         presents result 0 from the accepting edge.
module mul_unit_r4
  import mul_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  output logic             ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [TAG_W-1:0] tag_in,
  input  logic             flush,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  output logic             result_valid,
  output logic [TAG_W-1:0] tag_out,
  output logic [WIDTH-1:0] result
);

  localparam int EW   = WIDTH + 2;
  localparam int ITER = calc_iter(WIDTH);
  localparam int CW   = $clog2(ITER + 1);

  // Control state (reset)
  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [TAG_W-1:0] tag_q, tag_d;

  // Datapath state (no reset needed: always loaded at issue)
  mul_op_t          op_q, op_d;
  logic [EW-1:0]    mcand_q, mcand_d;
  logic [EW-1:0]    mplier_q, mplier_d;
  logic             bprev_q, bprev_d;   // bit below the current Booth window
  logic [EW+1:0]    hi_q, hi_d;         // running partial sum, upper part
  logic [EW-1:0]    lo_q, lo_d;         // product bits shifted out of hi

  logic             a_signed, b_signed;
  logic [EW-1:0]    a_ext, b_ext;
  logic [EW-1:0]    pp;
  logic [EW+1:0]    sum;
  logic [2*WIDTH-1:0] product;

  // Operand extension by the issuing op
  assign a_signed = (mul_op_t'(op) != MULHU);
  assign b_signed = (mul_op_t'(op) == MUL) || (mul_op_t'(op) == MULH);
  assign a_ext    = {{2{a_signed & src_a[WIDTH-1]}}, src_a};
  assign b_ext    = {{2{b_signed & src_b[WIDTH-1]}}, src_b};

  booth_r4_recode #(.EW(EW)) u_recode (
    .digit (({mplier_q[1:0], bprev_q})),
    .mcand (mcand_q),
    .pp    (pp)
  );

  // Each step adds the partial product at the current weight, then shifts the
  // accumulator right by one digit; after ITER steps {hi, lo} is the product.
  assign sum     = hi_q + {{2{pp[EW-1]}}, pp};
  assign product = (2*WIDTH)'({hi_q, lo_q});

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    tag_d    = tag_q;
    op_d     = op_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    bprev_d  = bprev_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          op_d     = mul_op_t'(op);
          tag_d    = tag_in;
          mcand_d  = a_ext;
          mplier_d = b_ext;
          bprev_d  = 1'b0;
          hi_d     = '0;
          lo_d     = '0;
          cnt_d    = CW'(ITER);
          state_d  = CALC;
`ifdef MUL_EARLY_ZERO_EN
          if ((src_a == '0) || (src_b == '0)) begin
            cnt_d    = '0;
            result_d = '0;
            state_d  = DONE;
          end
`endif
        end
      end
      CALC: begin
        if (cnt_q != '0) begin
          hi_d     = {{2{sum[EW+1]}}, sum[EW+1:2]};
          lo_d     = {sum[1:0], lo_q[EW-1:2]};
          mplier_d = {2'b00, mplier_q[EW-1:2]};
          bprev_d  = mplier_q[1];
          cnt_d    = cnt_q - CW'(1);
        end else begin
          result_d = (op_q == MUL) ? product[WIDTH-1:0]
                                   : product[2*WIDTH-1:WIDTH];
          state_d  = DONE;
        end
      end
      DONE: begin
        if (cdb_valid && (cdb_tag == tag_q)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Squash wins over issue and over CDB retire.
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      tag_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      tag_q    <= tag_d;
    end
  end

  always_ff @(posedge clk) begin
    op_q     <= op_d;
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
    bprev_q  <= bprev_d;
    hi_q     <= hi_d;
    lo_q     <= lo_d;
  end

  assign ready        = (state_q == IDLE);
  assign result_valid = (state_q == DONE);
  assign tag_out      = tag_q;
  assign result       = result_q;

endmodule

// File: tb/tb_mul_unit_r4.sv
// tb_mul_unit_r4 -- scoreboard bench for mul_unit_r4 (WIDTH=32, TAG_W=4).
// Issued operations push their hand-computed result, tag and latency into a
// queue; a monitor pops and compares whenever result_valid rises.
module tb_mul_unit_r4;

  localparam int WIDTH = 32;
  localparam int TAG_W = 4;
`ifdef MUL_EARLY_ZERO_EN
  localparam int ZERO_LAT = 0;   // DONE entered on the accepting edge
`else
  localparam int ZERO_LAT = 18;
`endif

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             start = 1'b0;
  logic             ready;
  logic [1:0]       op = 2'd0;
  logic [WIDTH-1:0] src_a = '0;
  logic [WIDTH-1:0] src_b = '0;
  logic [TAG_W-1:0] tag_in = '0;
  logic             flush = 1'b0;
  logic             cdb_valid = 1'b0;
  logic [TAG_W-1:0] cdb_tag = '0;
  logic             result_valid;
  logic [TAG_W-1:0] tag_out;
  logic [WIDTH-1:0] result;

  mul_unit_r4 #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .ready        (ready),
    .op           (op),
    .src_a        (src_a),
    .src_b        (src_b),
    .tag_in       (tag_in),
    .flush        (flush),
    .cdb_valid    (cdb_valid),
    .cdb_tag      (cdb_tag),
    .result_valid (result_valid),
    .tag_out      (tag_out),
    .result       (result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [WIDTH-1:0] res;
    int               lat;
    int               issue_cyc;
    string            name;
  } exp_t;

  exp_t sb[$];
  int checks_total  = 0;
  int checks_passed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: one comparison set per rising result_valid.
  initial begin
    logic prev_rv;
    exp_t e;
    prev_rv = 1'b0;
    forever begin
      @(negedge clk);
      if (result_valid && !prev_rv) begin
        if (sb.size() == 0) begin
          check("unexpected_result", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check({e.name, "_result"}, 64'(result), 64'(e.res));
          check({e.name, "_tag"}, 64'(tag_out), 64'(e.tag));
          check({e.name, "_latency"}, 64'(cyc - e.issue_cyc), 64'(e.lat));
          $display("txn %s tag=%0d result=0x%08h latency=%0d",
                   e.name, tag_out, result, cyc - e.issue_cyc);
        end
      end
      prev_rv = result_valid;
    end
  end

  task automatic issue(input logic [1:0] o, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input logic [TAG_W-1:0] t,
                       input bit push, input logic [WIDTH-1:0] exp_res,
                       input int lat, input string nm);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!ready) check({nm, "_ready_timeout"}, 64'd0, 64'd1);
    start  = 1'b1;
    op     = o;
    src_a  = a;
    src_b  = b;
    tag_in = t;
    if (push) begin
      e.tag = t; e.res = exp_res; e.lat = lat; e.issue_cyc = cyc + 1; e.name = nm;
      sb.push_back(e);
    end
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_rv(input string nm);
    int n;
    n = 0;
    while (!result_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!result_valid) check({nm, "_valid_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic retire(input logic [TAG_W-1:0] t, input string nm);
    wait_rv(nm);
    cdb_valid = 1'b1;
    cdb_tag   = t;
    @(posedge clk);
    #1 cdb_valid = 1'b0;
    check({nm, "_retire_rv"}, 64'(result_valid), 64'd0);
    check({nm, "_retire_ready"}, 64'(ready), 64'd1);
  endtask

  initial begin
    #2ms;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset values while reset_n is held low
    repeat (2) @(negedge clk);
    check("reset_ready", 64'(ready), 64'd1);
    check("reset_rv", 64'(result_valid), 64'd0);
    check("reset_result", 64'(result), 64'd0);
    check("reset_tag", 64'(tag_out), 64'd0);
    reset_n = 1'b1;

    // Basic op coverage
    issue(2'd0, 32'h0000_0007, 32'hFFFF_FFFD, 4'd1, 1'b1, 32'hFFFF_FFEB, 18, "mul_7xm3");
    retire(4'd1, "mul_7xm3");
    issue(2'd1, 32'h8000_0000, 32'h8000_0000, 4'd2, 1'b1, 32'h4000_0000, 18, "mulh_min");
    retire(4'd2, "mulh_min");
    issue(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd3, 1'b1, 32'hFFFF_FFFE, 18, "mulhu_max");
    retire(4'd3, "mulhu_max");
    issue(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd4, 1'b1, 32'hFFFF_FFFF, 18, "mulhsu_max");
    retire(4'd4, "mulhsu_max");
    issue(2'd0, 32'hFFFF_FFFB, 32'hFFFF_FFF9, 4'd11, 1'b1, 32'h0000_0023, 18, "mul_m5xm7");
    retire(4'd11, "mul_m5xm7");
    issue(2'd2, 32'h8000_0000, 32'h0000_0002, 4'd12, 1'b1, 32'hFFFF_FFFF, 18, "mulhsu_min_x2");
    retire(4'd12, "mulhsu_min_x2");
    issue(2'd3, 32'h8000_0000, 32'h0000_0002, 4'd13, 1'b1, 32'h0000_0001, 18, "mulhu_half_x2");
    retire(4'd13, "mulhu_half_x2");

    // CDB hold: a foreign tag must not retire the result
    issue(2'd0, 32'd6, 32'd7, 4'd5, 1'b1, 32'd42, 18, "cdb_hold");
    wait_rv("cdb_hold");
    cdb_valid = 1'b1;
    cdb_tag   = 4'd3;
    @(posedge clk);
    #1 cdb_valid = 1'b0;
    check("cdb_other_tag_rv", 64'(result_valid), 64'd1);
    check("cdb_other_tag_tag", 64'(tag_out), 64'd5);
    retire(4'd5, "cdb_hold");

    // start held during DONE is ignored
    issue(2'd3, 32'h1234_5678, 32'h0000_0010, 4'd6, 1'b1, 32'h0000_0001, 18, "start_in_done");
    wait_rv("start_in_done");
    @(negedge clk);
    start = 1'b1; op = 2'd0; src_a = 32'd3; src_b = 32'd5; tag_in = 4'd7;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("done_start_ready", 64'(ready), 64'd0);
      check("done_start_rv", 64'(result_valid), 64'd1);
      check("done_start_result", 64'(result), 64'h1);
      check("done_start_tag", 64'(tag_out), 64'd6);
    end
    start = 1'b0;
    retire(4'd6, "start_in_done");

    // Flush during CALC (cycle 6), then a clean issue
    issue(2'd0, 32'd9, 32'd9, 4'd7, 1'b0, '0, 0, "flushed");
    repeat (5) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    check("flush_rv", 64'(result_valid), 64'd0);
    check("flush_ready", 64'(ready), 64'd1);
    repeat (20) @(posedge clk);
    #1 check("flush_no_late_rv", 64'(result_valid), 64'd0);
    issue(2'd1, 32'hFFFF_FFFE, 32'd3, 4'd8, 1'b1, 32'hFFFF_FFFF, 18, "after_flush");
    retire(4'd8, "after_flush");

    // Asynchronous reset mid-CALC
    issue(2'd2, 32'd100, 32'd200, 4'd9, 1'b0, '0, 0, "reset_victim");
    repeat (4) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("midreset_ready", 64'(ready), 64'd1);
    check("midreset_rv", 64'(result_valid), 64'd0);
    check("midreset_result", 64'(result), 64'd0);
    check("midreset_tag", 64'(tag_out), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Zero operand (bypass only when the early-zero build is enabled)
    issue(2'd0, 32'd0, 32'h0000_1234, 4'd10, 1'b1, 32'd0, ZERO_LAT, "zero_operand");
    retire(4'd10, "zero_operand");

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
